// File: rtl/mpt_walk_arbiter.sv
// mpt_walk_arbiter: shares one MPT page-table walker between N_REQ requesters.
// Requesters are served round-robin, one walk at a time. The walker's
// permission result is combined with the requested access type into a single
// allow/deny response. A flush drains any in-flight walk and drops its result.

package mpt_pkg;

    localparam int PLEN = 56;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'b00,
        ACCESS_READ  = 2'b01,
        ACCESS_WRITE = 2'b10,
        ACCESS_EXEC  = 2'b11
    } mpt_access_e;

    typedef enum logic [1:0] {
        DISALLOWED = 2'b00,
        ALLOW_RX   = 2'b01,
        ALLOW_RW   = 2'b10,
        ALLOW_RWX  = 2'b11
    } TLB_permissions_e;

    typedef enum logic [2:0] {
        NO_ERROR           = 3'b000,
        ILLEGAL_MODE       = 3'b001,
        RESERVED_BITS_SET  = 3'b010,
        INVALID_MPTL1_INFO = 3'b011,
        INVALID_MPTL2_INFO = 3'b100
    } page_format_fault_e;

endpackage

module mpt_walk_arbiter #(
    parameter int N_REQ = 3,
    parameter int PLEN  = mpt_pkg::PLEN
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,

    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*PLEN-1:0]   req_paddr_i,
    input  logic [N_REQ*2-1:0]      req_access_i,

    output logic                    walk_valid_o,
    input  logic                    walk_ready_i,
    output logic [PLEN-1:0]         walk_paddr_o,
    input  logic                    walk_done_i,
    input  logic [1:0]              walk_perm_i,
    input  logic [2:0]              walk_fault_i,

    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic                    rsp_allow_o,
    output logic [2:0]              rsp_fault_o,
    output logic                    busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_e;

    state_e                    state_q;
    logic [IDX_W-1:0]          rr_ptr_q;
    logic [IDX_W-1:0]          owner_q;
    logic [PLEN-1:0]           paddr_q;
    mpt_pkg::mpt_access_e      access_q;
    logic                      walk_valid_q;
    logic [N_REQ-1:0]          rsp_valid_q;
    logic                      rsp_allow_q;
    logic [2:0]                rsp_fault_q;

    logic [IDX_W-1:0]          winner;
    logic                      any_valid;
    logic                      grant;
    logic [PLEN-1:0]           winner_paddr;
    mpt_pkg::mpt_access_e      winner_access;

    // Index (base + offset) modulo N_REQ; offset is always below N_REQ.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Permission check for a walk that completed without a format fault.
    function automatic logic allow_decode(input mpt_pkg::mpt_access_e acc, input logic [1:0] perm);
        logic ok;
        ok = 1'b0;
        case (acc)
            mpt_pkg::ACCESS_READ:  ok = (perm != mpt_pkg::DISALLOWED);
            mpt_pkg::ACCESS_WRITE: ok = (perm == mpt_pkg::ALLOW_RW) || (perm == mpt_pkg::ALLOW_RWX);
            mpt_pkg::ACCESS_EXEC:  ok = (perm == mpt_pkg::ALLOW_RX) || (perm == mpt_pkg::ALLOW_RWX);
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Round-robin search: scanning offsets from high to low and overwriting
    // leaves the requester closest to rr_ptr as the winner.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[wrap_idx(rr_ptr_q, k)]) begin
                winner    = wrap_idx(rr_ptr_q, k);
                any_valid = 1'b1;
            end
        end
    end

    // Grant qualification and selection of the winner's address and access.
    // Ready is also held low while reset is asserted so every output is zero then.
    always_comb begin
        grant         = (state_q == IDLE) && !flush_i && any_valid;
        req_ready_o   = (grant && rst_ni) ? onehot(winner) : '0;
        winner_paddr  = req_paddr_i[int'(winner)*PLEN +: PLEN];
        winner_access = mpt_pkg::mpt_access_e'(req_access_i[int'(winner)*2 +: 2]);
    end

    // Main controller: grant, issue, wait for completion, respond or drain.
    // A flush that lands on the same cycle the walker accepts the request still
    // has a walk in flight, so that case drains instead of returning to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            paddr_q      <= '0;
            access_q     <= mpt_pkg::ACCESS_NONE;
            walk_valid_q <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_allow_q  <= 1'b0;
            rsp_fault_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        paddr_q  <= winner_paddr;
                        access_q <= winner_access;
                        owner_q  <= winner;
                        rr_ptr_q <= wrap_idx(winner, 1);
                        if (winner_access == mpt_pkg::ACCESS_NONE) begin
                            state_q     <= RESP;
                            rsp_valid_q <= onehot(winner);
                            rsp_allow_q <= 1'b0;
                            rsp_fault_q <= mpt_pkg::NO_ERROR;
                        end else begin
                            state_q      <= ISSUE;
                            walk_valid_q <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (walk_ready_i) begin
                        walk_valid_q <= 1'b0;
                        state_q      <= flush_i ? DRAIN : WAIT;
                    end else if (flush_i) begin
                        walk_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end

                WAIT: begin
                    if (walk_done_i) begin
                        if (flush_i) begin
                            state_q <= IDLE;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= onehot(owner_q);
                            rsp_fault_q <= walk_fault_i;
                            rsp_allow_q <= (walk_fault_i == mpt_pkg::NO_ERROR) &&
                                           allow_decode(access_q, walk_perm_i);
                        end
                    end else if (flush_i) begin
                        state_q <= DRAIN;
                    end
                end

                RESP: begin
                    rsp_valid_q <= '0;
                    rsp_allow_q <= 1'b0;
                    rsp_fault_q <= '0;
                    state_q     <= IDLE;
                end

                DRAIN: begin
                    if (walk_done_i) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q      <= IDLE;
                    walk_valid_q <= 1'b0;
                    rsp_valid_q  <= '0;
                    rsp_allow_q  <= 1'b0;
                    rsp_fault_q  <= '0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        walk_valid_o = walk_valid_q;
        walk_paddr_o = paddr_q;
        rsp_valid_o  = rsp_valid_q;
        rsp_allow_o  = rsp_allow_q;
        rsp_fault_o  = rsp_fault_q;
        busy_o       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mpt_walk_arbiter.sv
// tb_mpt_walk_arbiter: directed bench for the MPT walk arbiter. Expected
// responses are queued as stimulus is issued; a monitor pops them whenever the
// arbiter pulses a response.

module tb_mpt_walk_arbiter;

    import mpt_pkg::*;

    localparam int NR = 3;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 flush;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [NR*PLEN-1:0]   req_paddr;
    logic [NR*2-1:0]      req_access;
    logic                 walk_valid;
    logic                 walk_ready;
    logic [PLEN-1:0]      walk_paddr;
    logic                 walk_done;
    logic [1:0]           walk_perm;
    logic [2:0]           walk_fault;
    logic [NR-1:0]        rsp_valid;
    logic                 rsp_allow;
    logic [2:0]           rsp_fault;
    logic                 busy;

    int                   compared   = 0;
    int                   mismatched = 0;
    logic [6:0]           expQ[$];
    logic [6:0]           monExp;
    logic [PLEN-1:0]      paddrTab[NR];

    always #5 clk = ~clk;

    mpt_walk_arbiter #(.N_REQ(NR), .PLEN(PLEN)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_paddr_i (req_paddr),
        .req_access_i(req_access),
        .walk_valid_o(walk_valid),
        .walk_ready_i(walk_ready),
        .walk_paddr_o(walk_paddr),
        .walk_done_i (walk_done),
        .walk_perm_i (walk_perm),
        .walk_fault_i(walk_fault),
        .rsp_valid_o (rsp_valid),
        .rsp_allow_o (rsp_allow),
        .rsp_fault_o (rsp_fault),
        .busy_o      (busy)
    );

    function automatic logic [NR-1:0] oneHot(input int i);
        return NR'(1 << i);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic [PLEN-1:0] paddr, input logic [1:0] acc);
        req_valid[idx]              = 1'b1;
        req_paddr[idx*PLEN +: PLEN] = paddr;
        req_access[idx*2 +: 2]      = acc;
        paddrTab[idx]               = paddr;
    endtask

    // Waits (bounded) for any grant and checks it is the expected requester.
    task automatic waitGrant(input logic [NR-1:0] expOh, input string name);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            if (req_ready != '0) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (seen) begin
            checkOutput(name, req_ready, expOh);
        end else begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: grant timeout, got none expected ready=%b", name, expOh);
        end
    endtask

    // Full transaction with the walker accepting immediately and finishing
    // doneDelay cycles after the handshake.
    task automatic doWalk(input int idx, input logic [1:0] acc, input logic [1:0] perm,
                          input logic [2:0] flt, input bit expAllow, input logic [2:0] expFault,
                          input int doneDelay, input bit dropValid);
        waitGrant(oneHot(idx), "grant");
        checkOutput("walk_valid_at_grant", walk_valid, 0);
        tick();
        if (dropValid) req_valid[idx] = 1'b0;
        if (acc == ACCESS_NONE) begin
            expQ.push_back({oneHot(idx), 1'b0, 3'b000});
            @(negedge clk);
            checkOutput("none_no_walk", walk_valid, 0);
            checkOutput("none_rsp_timing", rsp_valid, oneHot(idx));
            tick();
        end else begin
            walk_ready = 1'b1;
            @(negedge clk);
            checkOutput("walk_valid_t1", walk_valid, 1);
            checkOutput("walk_paddr", walk_paddr, paddrTab[idx]);
            tick();
            walk_ready = 1'b0;
            @(negedge clk);
            checkOutput("walk_valid_drop", walk_valid, 0);
            repeat (doneDelay - 1) tick();
            walk_done  = 1'b1;
            walk_perm  = perm;
            walk_fault = flt;
            expQ.push_back({oneHot(idx), expAllow, expFault});
            tick();
            walk_done  = 1'b0;
            walk_perm  = 2'b00;
            walk_fault = 3'b000;
            @(negedge clk);
            checkOutput("rsp_timing", rsp_valid, oneHot(idx));
            tick();
        end
    endtask

    // Scoreboard monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            if (rsp_valid != '0) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=%b expected none at %0t", rsp_valid, $time);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("rsp_owner", rsp_valid, monExp[6:4]);
                    checkOutput("rsp_allow", rsp_allow, monExp[3]);
                    checkOutput("rsp_fault", rsp_fault, monExp[2:0]);
                end
            end else begin
                checkOutput("rsp_idle_zero", {rsp_allow, rsp_fault}, 4'b0000);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_ni     = 1'b0;
        flush      = 1'b0;
        req_valid  = '0;
        req_paddr  = '0;
        req_access = '0;
        walk_ready = 1'b0;
        walk_done  = 1'b0;
        walk_perm  = 2'b00;
        walk_fault = 3'b000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", req_ready, 0);
        checkOutput("reset_walk_valid", walk_valid, 0);
        checkOutput("reset_walk_paddr", walk_paddr, 0);
        checkOutput("reset_rsp", {rsp_valid, rsp_allow, rsp_fault}, 0);
        checkOutput("reset_busy", busy, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        tick();

        // Round-robin: all three valid, order 0,1,2,0
        applyStimulus(0, 56'h00_0000_0000_A000, ACCESS_READ);
        applyStimulus(1, 56'h00_0000_0000_B000, ACCESS_WRITE);
        applyStimulus(2, 56'h00_0000_0000_C000, ACCESS_EXEC);
        doWalk(0, ACCESS_READ,  ALLOW_RW,  NO_ERROR, 1'b1, NO_ERROR, 1, 1'b0);
        doWalk(1, ACCESS_WRITE, ALLOW_RX,  NO_ERROR, 1'b0, NO_ERROR, 1, 1'b0);
        doWalk(2, ACCESS_EXEC,  ALLOW_RWX, NO_ERROR, 1'b1, NO_ERROR, 1, 1'b0);
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b0;
        doWalk(0, ACCESS_READ, DISALLOWED, NO_ERROR, 1'b0, NO_ERROR, 1, 1'b1);

        // Single request: grant T, ready T+1, done T+4, response T+5
        applyStimulus(1, 56'h0000_8000_1000, ACCESS_READ);
        doWalk(1, ACCESS_READ, ALLOW_RX, NO_ERROR, 1'b1, NO_ERROR, 3, 1'b1);
        @(negedge clk);
        checkOutput("single_busy_after", busy, 0);
        checkOutput("single_rsp_after", rsp_valid, 0);
        tick();

        // Permission decode and fault forwarding
        applyStimulus(2, 56'h00_0012_3456_7000, ACCESS_READ);
        doWalk(2, ACCESS_READ, ALLOW_RWX, INVALID_MPTL2_INFO, 1'b0, INVALID_MPTL2_INFO, 2, 1'b1);
        applyStimulus(0, 56'h00_0000_0002_0000, ACCESS_EXEC);
        doWalk(0, ACCESS_EXEC, ALLOW_RW, NO_ERROR, 1'b0, NO_ERROR, 2, 1'b1);
        applyStimulus(1, 56'h00_0000_0003_0000, ACCESS_WRITE);
        doWalk(1, ACCESS_WRITE, ALLOW_RWX, NO_ERROR, 1'b1, NO_ERROR, 2, 1'b1);

        // Flush two cycles after handshake, done three cycles later
        applyStimulus(2, 56'h00_0000_0004_0000, ACCESS_READ);
        waitGrant(3'b100, "flush_wait_grant");
        tick();
        req_valid[2] = 1'b0;
        walk_ready   = 1'b1;
        tick();
        walk_ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        walk_done = 1'b1;
        walk_perm = ALLOW_RWX;
        @(negedge clk);
        checkOutput("drain_busy_at_done", busy, 1);
        tick();
        walk_done = 1'b0;
        walk_perm = 2'b00;
        @(negedge clk);
        checkOutput("drain_busy_after", busy, 0);
        checkOutput("drain_no_rsp", rsp_valid, 0);
        tick();
        applyStimulus(0, 56'h00_0000_0005_0000, ACCESS_READ);
        doWalk(0, ACCESS_READ, ALLOW_RX, NO_ERROR, 1'b1, NO_ERROR, 1, 1'b1);

        // Flush coincident with walk completion
        applyStimulus(1, 56'h00_0000_0006_0000, ACCESS_WRITE);
        waitGrant(3'b010, "flush_coinc_grant");
        tick();
        req_valid[1] = 1'b0;
        walk_ready   = 1'b1;
        tick();
        walk_ready = 1'b0;
        tick();
        flush     = 1'b1;
        walk_done = 1'b1;
        walk_perm = ALLOW_RW;
        tick();
        flush     = 1'b0;
        walk_done = 1'b0;
        walk_perm = 2'b00;
        @(negedge clk);
        checkOutput("coinc_busy", busy, 0);
        checkOutput("coinc_no_rsp", rsp_valid, 0);
        tick();
        applyStimulus(0, 56'h00_0000_0007_0000, ACCESS_WRITE);
        doWalk(0, ACCESS_WRITE, ALLOW_RW, NO_ERROR, 1'b1, NO_ERROR, 1, 1'b1);

        // Flush held high blocks grants and leaves rr_ptr alone
        flush = 1'b1;
        applyStimulus(0, 56'h00_0000_0008_0000, ACCESS_READ);
        applyStimulus(2, 56'h00_0000_0009_0000, ACCESS_READ);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("flush_hold_ready", req_ready, 0);
            checkOutput("flush_hold_busy", busy, 0);
            tick();
        end
        flush = 1'b0;
        doWalk(2, ACCESS_READ, ALLOW_RX, NO_ERROR, 1'b1, NO_ERROR, 1, 1'b1);
        doWalk(0, ACCESS_READ, DISALLOWED, NO_ERROR, 1'b0, NO_ERROR, 1, 1'b1);

        // Walker backpressure: request held stable for five cycles
        applyStimulus(1, 56'h00_00AB_CDEF_1000, ACCESS_WRITE);
        waitGrant(3'b010, "bp_grant");
        tick();
        req_valid[1]          = 1'b0;
        req_paddr[PLEN +: PLEN] = 56'h00_FFFF_FFFF_F000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_walk_valid", walk_valid, 1);
            checkOutput("bp_walk_paddr", walk_paddr, 56'h00_00AB_CDEF_1000);
            tick();
        end
        walk_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_walk_valid_hs", walk_valid, 1);
        tick();
        walk_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_walk_valid_drop", walk_valid, 0);
        walk_done = 1'b1;
        walk_perm = ALLOW_RW;
        expQ.push_back({3'b010, 1'b1, 3'b000});
        tick();
        walk_done = 1'b0;
        walk_perm = 2'b00;
        @(negedge clk);
        checkOutput("bp_rsp_timing", rsp_valid, 3'b010);
        tick();

        // ACCESS_NONE: immediate deny, no walk
        applyStimulus(0, 56'h00_0000_000A_0000, ACCESS_NONE);
        doWalk(0, ACCESS_NONE, 2'b00, NO_ERROR, 1'b0, NO_ERROR, 1, 1'b1);

        // Asynchronous reset in the middle of a walk
        applyStimulus(1, 56'h00_0000_000B_0000, ACCESS_EXEC);
        waitGrant(3'b010, "rst_grant");
        tick();
        req_valid[1] = 1'b0;
        walk_ready   = 1'b1;
        tick();
        walk_ready   = 1'b0;
        req_valid[0] = 1'b1;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_walk_valid", walk_valid, 0);
        checkOutput("arst_walk_paddr", walk_paddr, 0);
        checkOutput("arst_rsp", {rsp_valid, rsp_allow, rsp_fault}, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_ready", req_ready, 0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        walk_done = 1'b1;
        walk_perm = ALLOW_RWX;
        tick();
        walk_done = 1'b0;
        walk_perm = 2'b00;
        @(negedge clk);
        checkOutput("stale_done_busy", busy, 0);
        checkOutput("stale_done_rsp", rsp_valid, 0);
        tick();

        // After reset the pointer restarts at requester 0
        applyStimulus(0, 56'h00_0000_000C_0000, ACCESS_READ);
        applyStimulus(2, 56'h00_0000_000D_0000, ACCESS_WRITE);
        doWalk(0, ACCESS_READ,  ALLOW_RX, NO_ERROR, 1'b1, NO_ERROR, 1, 1'b1);
        doWalk(2, ACCESS_WRITE, ALLOW_RX, NO_ERROR, 1'b0, NO_ERROR, 1, 1'b1);

        repeat (3) tick();
        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
